// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: colour table, mode encoding and index stepping shared by the RGB sequencer.
package rgb_seq_pkg;
  localparam logic [7:0][23:0] COLOUR_LUT = {
    24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
    24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000
  };
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  typedef enum logic [1:0] {MODE_FWD = 2'b00, MODE_REV = 2'b01, MODE_PING = 2'b10} mode_e;
  typedef struct packed {
    logic [2:0] idx;
    logic       dir;
    logic       wrap;
  } step_t;
  // Mode 11 falls through to forward; dir only moves in ping-pong.
  function automatic step_t next_step(input logic [2:0] idx, input logic dir, input logic [1:0] mode,
                                      input logic [2:0] lo, input logic [2:0] hi);
    if (mode == MODE_REV)
      return (idx == lo) ? step_t'{hi, dir, 1'b1} : step_t'{idx - 3'd1, dir, 1'b0};
    if (mode == MODE_PING && dir)
      return (idx == lo) ? step_t'{idx + 3'd1, 1'b0, 1'b1} : step_t'{idx - 3'd1, 1'b1, 1'b0};
    if (mode == MODE_PING)
      return (idx == hi) ? step_t'{idx - 3'd1, 1'b1, 1'b1} : step_t'{idx + 3'd1, 1'b0, 1'b0};
    return (idx == hi) ? step_t'{lo, dir, 1'b1} : step_t'{idx + 3'd1, dir, 1'b0};
  endfunction
  function automatic logic [2:0] clamp_idx(input logic [2:0] v, input logic [2:0] lo, input logic [2:0] hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction
endpackage

// File: rtl/rgb_seq_channel.sv
// rgb_seq_channel: one light channel - dwell counter, index/direction state and 2-stage colour pipe.
module rgb_seq_channel
  import rgb_seq_pkg::*;
#(
  parameter int THR_W   = 6,
  parameter int SEQ_MIN = 1,
  parameter int SEQ_MAX = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [THR_W-1:0] i_threshold,
  input  logic             i_button,
  input  logic             i_sel,
  input  logic [1:0]       i_mode,
  input  logic             i_ld_valid,
  input  logic [2:0]       i_ld_index,
  output logic [23:0]      o_lights,
  output logic             o_wrap
);
  localparam logic [2:0] LO = 3'(SEQ_MIN);
  localparam logic [2:0] HI = 3'(SEQ_MAX);
  logic [2:0]       r_idx;
  logic [THR_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_wrap;
  logic [23:0]      r_lut;
  logic [23:0]      r_out;
  step_t            w_step;
  logic             w_adv;
  always_comb begin
    w_step = next_step(r_idx, r_dir, i_mode, LO, HI);
    w_adv  = i_button && (r_cnt >= i_threshold);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= LO;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_wrap <= 1'b0;
      r_lut  <= COLOUR_LUT[LO];
      r_out  <= i_sel ? COLOUR_LUT[LO] : WHITE;
    end else begin
      r_lut  <= COLOUR_LUT[r_idx];
      r_out  <= i_sel ? r_lut : WHITE;
      r_wrap <= !i_ld_valid && w_adv && w_step.wrap;
      if (i_ld_valid) begin
        r_idx <= clamp_idx(i_ld_index, LO, HI);
        r_cnt <= '0;
      end else if (w_adv) begin
        r_idx <= w_step.idx;
        r_dir <= w_step.dir;
        r_cnt <= '0;
      end else if (i_button) begin
        r_cnt <= r_cnt + THR_W'(1);
      end
    end
  end
  assign o_lights = r_out;
  assign o_wrap   = r_wrap;
endmodule

// File: rtl/rgb_seq_multi.sv
// rgb_seq_multi: NUM_CH independent RGB colour sequencers sharing one dwell threshold.
module rgb_seq_multi
  import rgb_seq_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int THR_W   = 6,
  parameter int SEQ_MIN = 1,
  parameter int SEQ_MAX = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [THR_W-1:0]     threshold,
  input  logic [NUM_CH-1:0]    button,
  input  logic [NUM_CH-1:0]    lights_sel,
  input  logic [2*NUM_CH-1:0]  mode,
  input  logic [NUM_CH-1:0]    ld_valid,
  input  logic [3*NUM_CH-1:0]  ld_index,
  output logic [24*NUM_CH-1:0] lights_out,
  output logic [NUM_CH-1:0]    wrap
);
  // rst_n is active-high despite its name; kept to match the surrounding top level.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rgb_seq_channel #(.THR_W(THR_W), .SEQ_MIN(SEQ_MIN), .SEQ_MAX(SEQ_MAX)) u_ch (
      .clk        (clk),
      .rst        (rst_n),
      .i_threshold(threshold),
      .i_button   (button[k]),
      .i_sel      (lights_sel[k]),
      .i_mode     (mode[2*k+:2]),
      .i_ld_valid (ld_valid[k]),
      .i_ld_index (ld_index[3*k+:3]),
      .o_lights   (lights_out[24*k+:24]),
      .o_wrap     (wrap[k])
    );
  end
endmodule
